// File: rtl/tri_state_bank_if.sv
// Control/status bundle between protocol logic and the pad bank.
// Pads stay a plain inout net on the bank so tri-state resolution is top-level.
interface tri_state_bank_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] send;
    logic [WIDTH-1:0] read;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] busy;
    logic [WIDTH-1:0] driving;

    modport master (
        output dir, send,
        input  read, rise, fall, busy, driving
    );

    modport slave (
        input  dir, send,
        output read, rise, fall, busy, driving
    );
endinterface

// File: rtl/tri_state_bank.sv
// Registered bank of bidirectional pads: drive/release FSM with turnaround
// guard, optional open-drain drive, 2-flop sync, glitch filter, edge pulses.
module tri_state_bank #(
    parameter int WIDTH       = 4,
    parameter int TURN_CYCLES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int OPEN_DRAIN  = 0,
    parameter int RESET_LEVEL = 1
) (
    input  logic              clock,
    input  logic              reset,
    inout  wire [WIDTH-1:0]   port,
    tri_state_bank_if.slave   bus
);
    localparam int TCW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [TCW-1:0] TSTART =
        TCW'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
    localparam logic [FCW-1:0] FLAST = FCW'(FILTER_LEN - 1);
    localparam logic RL = (RESET_LEVEL != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRIVE = 2'd2
    } state_t;

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        state_t         st, st_n;
        logic [TCW-1:0] cnt, cnt_n;
        logic [FCW-1:0] fcnt;
        logic           send_q;
        logic           ff1, ff2;
        logic           rd, rs, fl;
        logic           drv;

        always_comb begin
            st_n  = st;
            cnt_n = cnt;
            unique case (st)
                IDLE: begin
                    if (bus.dir[g]) begin
                        if (TURN_CYCLES == 0) begin
                            st_n = DRIVE;
                        end else begin
                            st_n  = WAIT;
                            cnt_n = TSTART;
                        end
                    end
                end
                WAIT: begin
                    if (!bus.dir[g]) begin
                        st_n = IDLE;
                    end else if (cnt == '0) begin
                        st_n = DRIVE;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                DRIVE: begin
                    if (!bus.dir[g]) begin
                        st_n = IDLE;
                    end
                end
                default: st_n = IDLE;
            endcase
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                st     <= IDLE;
                cnt    <= '0;
                send_q <= 1'b0;
            end else begin
                st     <= st_n;
                cnt    <= cnt_n;
                send_q <= bus.send[g];
            end
        end

        // Filter flips read only after FILTER_LEN straight disagreeing samples.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                ff1  <= RL;
                ff2  <= RL;
                rd   <= RL;
                fcnt <= '0;
                rs   <= 1'b0;
                fl   <= 1'b0;
            end else begin
                ff1 <= port[g];
                ff2 <= ff1;
                rs  <= 1'b0;
                fl  <= 1'b0;
                if (ff2 != rd) begin
                    if (fcnt == FLAST) begin
                        rd   <= ff2;
                        fcnt <= '0;
                        rs   <= ff2;
                        fl   <= !ff2;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end else begin
                    fcnt <= '0;
                end
            end
        end

        assign drv = (st == DRIVE);

        if (OPEN_DRAIN != 0) begin : g_od
            assign port[g] = (drv && !send_q) ? 1'b0 : 1'bz;
        end else begin : g_pp
            assign port[g] = drv ? send_q : 1'bz;
        end

        assign bus.read[g]    = rd;
        assign bus.rise[g]    = rs;
        assign bus.fall[g]    = fl;
        assign bus.busy[g]    = (st == WAIT);
        assign bus.driving[g] = drv;
    end
endmodule
